// File: rtl/tdc_reg_ctrl.sv
// rtl/tdc_reg_ctrl.sv - register bank with SPI/core arbitration, CTRL strobes and STATUS flags
module tdc_reg_ctrl #(
    parameter int                      ADDR_W  = 3,
    parameter int                      REG_W   = 8,
    parameter logic [(2**ADDR_W)-1:0]  RO_MASK = 8'hF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [REG_W-1:0]  spi_wdata,
    input  logic              spi_wdv,
    output logic [REG_W-1:0]  spi_rdata,
    output logic [31:0]       status_o,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [REG_W-1:0]  core_wdata,
    output logic              core_gnt,
    output logic [REG_W-1:0]  core_rdata,
    output logic              core_rvalid,
    input  logic              evt_done,
    input  logic              evt_ovf,
    output logic              ctrl_enable,
    output logic              start_pulse,
    output logic              soft_rst
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] A_CTRL = '0;
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(1);

    logic [REG_W-1:0] bank [DEPTH];
    logic [7:0]       wr_cnt;
    logic [7:0]       err_cnt;

    logic       spi_ok;
    logic       core_ok;
    logic       soft_hit;
    logic       core_wr;
    logic       core_rd;
    logic [1:0] stat_clr;
    logic [1:0] stat_next;

    always_comb begin
        spi_ok    = (spi_addr == A_CTRL) || (spi_addr == A_STAT) || !RO_MASK[spi_addr];
        core_ok   = RO_MASK[core_addr] && (core_addr != A_CTRL) && (core_addr != A_STAT);
        soft_hit  = spi_wdv && (spi_addr == A_CTRL) && spi_wdata[7];
        core_wr   = core_gnt && core_we;
        core_rd   = core_gnt && !core_we;
        stat_clr  = (spi_wdv && spi_addr == A_STAT) ? spi_wdata[1:0] : 2'b00;
        // Event set takes precedence over a same-cycle W1C of the same bit
        stat_next = (bank[1][1:0] & ~stat_clr) | {evt_ovf, evt_done};
    end

    assign core_gnt    = core_req && !spi_wdv && !rst;
    assign ctrl_enable = bank[0][0];
    assign status_o    = {err_cnt, wr_cnt, 8'h00, bank[1][7:0]};

    always_ff @(posedge clk) begin
        if (rst || soft_hit) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            bank[1] <= {{(REG_W-2){1'b0}}, stat_next};
            if (spi_wdv) begin
                if (spi_ok) begin
                    if (spi_addr == A_CTRL) begin
                        bank[0] <= {{(REG_W-1){1'b0}}, spi_wdata[0]};
                    end else if (spi_addr != A_STAT) begin
                        bank[spi_addr] <= spi_wdata;
                    end
                    wr_cnt <= wr_cnt + 8'd1;
                end else if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (core_wr) begin
                if (core_ok) begin
                    bank[core_addr] <= core_wdata;
                end else if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_rdata   <= '0;
            core_rdata  <= '0;
            core_rvalid <= 1'b0;
            start_pulse <= 1'b0;
            soft_rst    <= 1'b0;
        end else begin
            spi_rdata   <= bank[spi_addr];
            core_rvalid <= core_rd;
            if (core_rd) begin
                core_rdata <= bank[core_addr];
            end
            start_pulse <= spi_wdv && (spi_addr == A_CTRL) && spi_wdata[1];
            soft_rst    <= soft_hit;
        end
    end

endmodule

// File: tb/tb_tdc_reg_ctrl.sv
// tb/tb_tdc_reg_ctrl.sv - directed self-checking bench for tdc_reg_ctrl
module tb_tdc_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] spi_addr;
    logic [7:0] spi_wdata;
    logic       spi_wdv;
    logic [7:0] spi_rdata;
    logic [31:0] status_o;
    logic       core_req;
    logic       core_we;
    logic [2:0] core_addr;
    logic [7:0] core_wdata;
    logic       core_gnt;
    logic [7:0] core_rdata;
    logic       core_rvalid;
    logic       evt_done;
    logic       evt_ovf;
    logic       ctrl_enable;
    logic       start_pulse;
    logic       soft_rst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdc_reg_ctrl dut (
        .clk(clk), .rst(rst),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wdv(spi_wdv),
        .spi_rdata(spi_rdata), .status_o(status_o),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata),
        .core_rvalid(core_rvalid), .evt_done(evt_done), .evt_ovf(evt_ovf),
        .ctrl_enable(ctrl_enable), .start_pulse(start_pulse), .soft_rst(soft_rst)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_wr(input logic [2:0] a, input logic [7:0] d);
        spi_addr  = a;
        spi_wdata = d;
        spi_wdv   = 1'b1;
        step();
        spi_wdv   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; spi_addr = '0; spi_wdata = '0; spi_wdv = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        evt_done = 1'b0; evt_ovf = 1'b0;
        step(); step();
        rst = 1'b0;
        check("reset_status", status_o, 32'h0);
        check("reset_rdata", 32'(spi_rdata), 32'h0);
        check("reset_rvalid", 32'(core_rvalid), 32'h0);
        check("reset_strobes", 32'({start_pulse, soft_rst, ctrl_enable}), 32'h0);

        // 1: plain SPI write and readback
        spi_wr(3'd2, 8'h5A);
        spi_addr = 3'd2;
        step();
        check("t1_rdata", 32'(spi_rdata), 32'h5A);
        check("t1_status", status_o, 32'h0001_0000);

        // 2: SPI write collides with core read of the same address
        spi_addr = 3'd3; spi_wdata = 8'hA5; spi_wdv = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 3'd3;
        #1;
        check("t2_gnt_blocked", 32'(core_gnt), 32'h0);
        step();
        spi_wdv = 1'b0;
        #1;
        check("t2_gnt_next", 32'(core_gnt), 32'h1);
        step();
        core_req = 1'b0;
        check("t2_rvalid", 32'(core_rvalid), 32'h1);
        check("t2_rdata", 32'(core_rdata), 32'hA5);
        step();
        check("t2_rvalid_pulse", 32'(core_rvalid), 32'h0);

        // 3: read-only ownership rules
        spi_wr(3'd5, 8'hFF);
        check("t3_spi_ro_err", status_o, 32'h0102_0000);
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd5; core_wdata = 8'h33;
        #1;
        check("t3_core_gnt", 32'(core_gnt), 32'h1);
        step();
        core_req = 1'b0;
        check("t3_no_rvalid_on_write", 32'(core_rvalid), 32'h0);
        spi_addr = 3'd5;
        step();
        check("t3_core_wr_ro", 32'(spi_rdata), 32'h33);
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd2; core_wdata = 8'h77;
        #1;
        check("t3_core_gnt_rej", 32'(core_gnt), 32'h1);
        step();
        core_req = 1'b0;
        spi_addr = 3'd2;
        step();
        check("t3_core_wr_dropped", 32'(spi_rdata), 32'h5A);
        check("t3_err2", status_o, 32'h0202_0000);

        // 4: STATUS sticky bits and W1C with set priority
        evt_done = 1'b1;
        step();
        evt_done = 1'b0;
        check("t4_done_set", status_o, 32'h0202_0001);
        evt_done = 1'b1;
        spi_wr(3'd1, 8'h01);
        evt_done = 1'b0;
        check("t4_set_wins", status_o, 32'h0203_0001);
        spi_wr(3'd1, 8'h01);
        check("t4_w1c", status_o, 32'h0204_0000);
        evt_ovf = 1'b1;
        step();
        evt_ovf = 1'b0;
        spi_wr(3'd1, 8'h01);
        check("t4_ovf_kept", status_o, 32'h0205_0002);

        // 5: CTRL enable, start and soft reset
        spi_wr(3'd0, 8'h01);
        check("t5_enable", 32'(ctrl_enable), 32'h1);
        check("t5_no_strobe", 32'({start_pulse, soft_rst}), 32'h0);
        spi_wr(3'd0, 8'h83);
        check("t5_strobes", 32'({start_pulse, soft_rst}), 32'h3);
        check("t5_enable_cleared", 32'(ctrl_enable), 32'h0);
        check("t5_status_cleared", status_o, 32'h0);
        spi_addr = 3'd2;
        step();
        check("t5_strobes_once", 32'({start_pulse, soft_rst}), 32'h0);
        check("t5_bank_cleared", 32'(spi_rdata), 32'h0);
        spi_wr(3'd0, 8'h03);
        check("t5_start_only", 32'({start_pulse, soft_rst, ctrl_enable}), 32'h5);
        check("t5_wr1", status_o, 32'h0001_0000);
        spi_addr = 3'd0;
        step();
        check("t5_ctrl_readback", 32'(spi_rdata), 32'h01);

        // 6: counter saturation and wrap
        spi_wr(3'd0, 8'h80);
        check("t6_cleared", status_o, 32'h0);
        for (int i = 0; i < 300; i++) begin
            spi_wr(3'd6, 8'(i));
        end
        check("t6_err_sat", status_o, 32'hFF00_0000);
        for (int i = 0; i < 255; i++) begin
            spi_wr(3'd2, 8'(i));
        end
        check("t6_wr_ff", status_o, 32'hFF_FF_0000);
        spi_wr(3'd2, 8'hC3);
        check("t6_wr_wrap", status_o, 32'hFF00_0000);
        spi_addr = 3'd2;
        step();
        check("t6_last_data", 32'(spi_rdata), 32'hC3);

        // 7: reset during a pending core read
        core_req = 1'b1; core_we = 1'b0; core_addr = 3'd2;
        rst = 1'b1;
        #1;
        check("t7_gnt_cancel", 32'(core_gnt), 32'h0);
        step();
        check("t7_rvalid_cancel", 32'(core_rvalid), 32'h0);
        check("t7_rst_status", status_o, 32'h0);
        rst = 1'b0;
        #1;
        check("t7_rerequest", 32'(core_gnt), 32'h1);
        step();
        core_req = 1'b0;
        check("t7_rdata_zero", 32'({core_rvalid, core_rdata}), 32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdc_reg_ctrl.md
Name: tdc_reg_ctrl

Overview:
Register-bank controller behind the SPI register slave. It owns the 2**ADDR_W x REG_W register bank and arbitrates single-port bank access between two masters: SPI transactions (config writes, readback) and the TDC core (result writes, config reads). It also decodes the CTRL and STATUS registers into control strobes and sticky flags, and assembles the 32-bit status word preloaded into the SPI shifter.

Parameters:
ADDR_W, 3, register address width; bank depth = 2**ADDR_W (minimum 2)
REG_W, 8, register data width (minimum 8)
RO_MASK, 8'hF0, bit i = 1: address i is core-writable and SPI-read-only; bits 0 and 1 are ignored (CTRL and STATUS are always SPI-owned)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
spi_addr  in  ADDR_W  register address from SPI slave
spi_wdata  in  REG_W  SPI write data
spi_wdv  in  1  one-cycle SPI write strobe
spi_rdata  out  REG_W  readback data for spi_addr
status_o  out  32  {err_cnt, wr_cnt, 8'h00, STATUS}
core_req  in  1  core access request, held until granted
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  core address
core_wdata  in  REG_W  core write data
core_gnt  out  1  one-cycle grant
core_rdata  out  REG_W  core read data
core_rvalid  out  1  pulse one cycle after a granted read
evt_done  in  1  sets STATUS[0]
evt_ovf  in  1  sets STATUS[1]
ctrl_enable  out  1  CTRL[0]
start_pulse  out  1  one-cycle start strobe
soft_rst  out  1  one-cycle soft-reset strobe

Behaviour:
- Reset (rst=1 at a clk edge): all bank entries, wr_cnt and err_cnt = 0. spi_rdata, core_gnt, core_rdata, core_rvalid, start_pulse and soft_rst = 0.
- Address 0, CTRL: bit0 = enable (stored). Bits 1 and 7 are not stored. Bit1 = 1 on an SPI write gives start_pulse = 1 in the next cycle. Bit7 = 1 on an SPI write gives soft_rst = 1 in the next cycle, and in that same cycle the bank and both counters clear to reset values.
- Address 1, STATUS: write-1-to-clear from SPI. A cycle with evt_* = 1 sets the matching bit. If set and clear hit the same bit in one cycle, set wins.
- Arbitration, evaluated every cycle:
  - spi_wdv has absolute priority and is never stalled.
  - core_gnt = core_req & ~spi_wdv, combinational in the request cycle. The core holds req/we/addr/wdata stable until it sees the grant.
- SPI write: accepted if spi_addr is 0, 1 or not in RO_MASK. Bank updates on the same edge and wr_cnt increments (wrapping). Otherwise the write is dropped and err_cnt increments (saturating at 2**8-1).
- Core write: accepted only if the address is in RO_MASK and is not 0 or 1. Otherwise it is dropped, err_cnt increments, and core_gnt is still issued.
- Core read: granted read at cycle N gives core_rdata = bank[core_addr] and core_rvalid = 1 at N+1. Any address is readable.
- spi_rdata is registered from bank[spi_addr] every cycle. A write at edge N is visible at edge N+1.
- status_o is combinational from registers.
- Simultaneous SPI write and core request: the core is not granted that cycle and is granted the following cycle if spi_wdv = 0.
- rst asserted mid-handshake: a pending grant or rvalid is cancelled. The core must re-request.

Test Plan:
1. Reset, then SPI write addr 2 = 0x5A -> bank[2] = 0x5A, spi_rdata = 0x5A one cycle later, wr_cnt = 1, status_o[23:16] = 0x01.
2. Same-cycle SPI write addr 3 and core read addr 3 -> core_gnt = 0 in that cycle; gnt the next cycle; core_rdata = new value with rvalid one cycle after gnt.
3. SPI write addr 5 = 0xFF (RO) -> bank[5] unchanged, err_cnt = 1. Core write addr 5 = 0x33 -> spi_rdata = 0x33. Core write addr 2 -> dropped, err_cnt = 2.
4. evt_done pulse, then SPI write STATUS = 0x01 in the same cycle as evt_done = 1 -> STATUS[0] remains 1. A later W1C without the event -> STATUS[0] = 0.
5. SPI write CTRL = 0x83 -> next cycle start_pulse = 1, soft_rst = 1 (one cycle each), then bank all 0, ctrl_enable = 0, counters 0.
6. 300 rejected writes -> err_cnt saturates at 0xFF. 256 accepted writes -> wr_cnt wraps to 0.
